// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32 core's memory access path.
//   XLEN / XBYTES   datapath width and byte-lane count (only 32 / 4 supported)
//   lsu_state_e     load/store unit sequencing states
//   F3_*            RV32I load/store width codes carried in funct3
//   lsu_req_legal   width/alignment legality check for a load or store request
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int XBYTES = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths exist only for loads; halfwords need an even address
  // and words a 4-byte aligned one. Every other funct3 code is rejected.
  function automatic logic lsu_req_legal(input logic       store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~store;
      F3_HU:   ok = ~store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load data alignment and extension.
//   funct3_in   RV32I load width/sign code
//   addr_lo_in  byte offset of the load within the word
//   rdata_in    raw word returned by data memory
//   data_out    selected byte/half/word, sign- or zero-extended to XLEN
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3_in,
  input  logic [1:0]      addr_lo_in,
  input  logic [XLEN-1:0] rdata_in,
  output logic [XLEN-1:0] data_out
);

  logic [XLEN-1:0] shifted;

  // Bring the addressed byte lane down to bit 0, then extend by width.
  always_comb begin
    shifted  = rdata_in >> {addr_lo_in, 3'b000};
    data_out = shifted;
    case (funct3_in)
      F3_B:    data_out = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    data_out = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   data_out = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   data_out = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data_out = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access unit of the RV32 core.
//   clk_in / rst_in          clock (rising edge) and async active-high reset
//   req_*_in                 load/store request from the execute stage
//   busy_out                 combinational pipeline stall request
//   fault_out                1-cycle pulse for a misaligned/illegal request
//   dmem_*                   data-memory request/response handshake
//   load_valid_out           1-cycle pulse when load_data_out/load_rd_out update
//   load_data_out            extended load result for the writeback mux
//   load_rd_out              destination register of the returned load
module load_store_unit
  import riscv_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid_in,
  input  logic              req_store_in,
  input  logic [2:0]        req_funct3_in,
  input  logic [XLEN-1:0]   req_addr_in,
  input  logic [XLEN-1:0]   req_wdata_in,
  input  logic [4:0]        req_rd_in,
  output logic              busy_out,
  output logic              fault_out,
  output logic              dmem_req_valid_out,
  input  logic              dmem_req_ready_in,
  output logic [XLEN-1:0]   dmem_addr_out,
  output logic              dmem_we_out,
  output logic [XBYTES-1:0] dmem_be_out,
  output logic [XLEN-1:0]   dmem_wdata_out,
  input  logic              dmem_rsp_valid_in,
  input  logic [XLEN-1:0]   dmem_rdata_in,
  output logic              load_valid_out,
  output logic [XLEN-1:0]   load_data_out,
  output logic [4:0]        load_rd_out
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XBYTES-1:0] be_q, be_d;
  logic              we_q, we_d;
  logic [4:0]        rd_q, rd_d;
  logic              fault_q, fault_d;
  logic              load_valid_q, load_valid_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic [4:0]        load_rd_q, load_rd_d;

  logic              req_legal;
  logic              accept;
  logic [XLEN-1:0]   aligned_data;

  assign req_legal = lsu_req_legal(req_store_in, req_funct3_in, req_addr_in[1:0]);
  assign accept    = (state_q == IDLE) & req_valid_in & req_legal;

  load_align u_load_align (
    .funct3_in  (funct3_q),
    .addr_lo_in (addr_q[1:0]),
    .rdata_in   (dmem_rdata_in),
    .data_out   (aligned_data)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      rd_q         <= '0;
      fault_q      <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      fault_q      <= fault_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      load_rd_q    <= load_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (dmem_req_ready_in) state_d = we_q ? IDLE : RSP;
      RSP:     if (dmem_rsp_valid_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only on accept so the memory-side outputs
  // stay stable for as long as the memory holds off ready.
  always_comb begin
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    rd_d         = rd_q;
    fault_d      = 1'b0;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    load_rd_d    = load_rd_q;

    if ((state_q == IDLE) && req_valid_in && !req_legal) begin
      fault_d = 1'b1;
    end

    if (accept) begin
      funct3_d = req_funct3_in;
      addr_d   = req_addr_in;
      rd_d     = req_rd_in;
      we_d     = req_store_in;
      be_d     = 4'b1111;
      wdata_d  = req_wdata_in;
      if (req_store_in) begin
        case (req_funct3_in)
          F3_B: begin
            be_d    = 4'b0001 << req_addr_in[1:0];
            wdata_d = {4{req_wdata_in[7:0]}};
          end
          F3_H: begin
            be_d    = 4'b0011 << req_addr_in[1:0];
            wdata_d = {2{req_wdata_in[15:0]}};
          end
          default: ;
        endcase
      end
    end

    if ((state_q == RSP) && dmem_rsp_valid_in) begin
      load_valid_d = 1'b1;
      load_data_d  = aligned_data;
      load_rd_d    = rd_q;
    end
  end

  // Busy includes the accepting cycle so the requesting instruction is held
  // in execute before the state register has moved.
  always_comb begin
    busy_out           = (state_q != IDLE) | accept;
    dmem_req_valid_out = (state_q == REQ);
    fault_out          = fault_q;
    dmem_addr_out      = {addr_q[XLEN-1:2], 2'b00};
    dmem_we_out        = we_q;
    dmem_be_out        = be_q;
    dmem_wdata_out     = wdata_q;
    load_valid_out     = load_valid_q;
    load_data_out      = load_data_q;
    load_rd_out        = load_rd_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk_in;
  logic        rst_in;
  logic        req_valid_in;
  logic        req_store_in;
  logic [2:0]  req_funct3_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [4:0]  req_rd_in;
  logic        busy_out;
  logic        fault_out;
  logic        dmem_req_valid_out;
  logic        dmem_req_ready_in;
  logic [31:0] dmem_addr_out;
  logic        dmem_we_out;
  logic [3:0]  dmem_be_out;
  logic [31:0] dmem_wdata_out;
  logic        dmem_rsp_valid_in;
  logic [31:0] dmem_rdata_in;
  logic        load_valid_out;
  logic [31:0] load_data_out;
  logic [4:0]  load_rd_out;

  int checkCount;
  int errorCount;

  load_store_unit dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .req_valid_in       (req_valid_in),
    .req_store_in       (req_store_in),
    .req_funct3_in      (req_funct3_in),
    .req_addr_in        (req_addr_in),
    .req_wdata_in       (req_wdata_in),
    .req_rd_in          (req_rd_in),
    .busy_out           (busy_out),
    .fault_out          (fault_out),
    .dmem_req_valid_out (dmem_req_valid_out),
    .dmem_req_ready_in  (dmem_req_ready_in),
    .dmem_addr_out      (dmem_addr_out),
    .dmem_we_out        (dmem_we_out),
    .dmem_be_out        (dmem_be_out),
    .dmem_wdata_out     (dmem_wdata_out),
    .dmem_rsp_valid_in  (dmem_rsp_valid_in),
    .dmem_rdata_in      (dmem_rdata_in),
    .load_valid_out     (load_valid_out),
    .load_data_out      (load_data_out),
    .load_rd_out        (load_rd_out)
  );

  // Free-running 10-unit clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Advance one clock and land 1 unit after the rising edge so that both
  // driving and sampling happen away from the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present a request on the execute-side inputs and let combinational
  // outputs settle before anything is sampled.
  task automatic applyStimulus(input logic valid, input logic store,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd);
    req_valid_in  = valid;
    req_store_in  = store;
    req_funct3_in = f3;
    req_addr_in   = addr;
    req_wdata_in  = wdata;
    req_rd_in     = rd;
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts and reports the error.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Minimum-latency load: accept, REQ with ready, RSP with rsp_valid, then
  // the result pulse; the result must also hold one cycle later.
  task automatic runLoad(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] expData);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, rd);
    checkOutput({tag, "_busy_accept"}, {31'b0, busy_out}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_req_ready_in = 1'b1;
    checkOutput({tag, "_req_valid"}, {31'b0, dmem_req_valid_out}, 32'd1);
    checkOutput({tag, "_addr"}, dmem_addr_out, {addr[31:2], 2'b00});
    checkOutput({tag, "_be"}, {28'b0, dmem_be_out}, 32'hF);
    checkOutput({tag, "_we"}, {31'b0, dmem_we_out}, 32'd0);
    tick();
    dmem_req_ready_in = 1'b0;
    dmem_rsp_valid_in = 1'b1;
    dmem_rdata_in     = rdata;
    #1;
    checkOutput({tag, "_rsp_busy"}, {31'b0, busy_out}, 32'd1);
    tick();
    dmem_rsp_valid_in = 1'b0;
    dmem_rdata_in     = 32'h0;
    #1;
    checkOutput({tag, "_load_valid"}, {31'b0, load_valid_out}, 32'd1);
    checkOutput({tag, "_data"}, load_data_out, expData);
    checkOutput({tag, "_rd"}, {27'b0, load_rd_out}, {27'b0, rd});
    checkOutput({tag, "_busy_done"}, {31'b0, busy_out}, 32'd0);
    tick();
    checkOutput({tag, "_valid_drop"}, {31'b0, load_valid_out}, 32'd0);
    checkOutput({tag, "_data_hold"}, load_data_out, expData);
  endtask

  // Directed scenario sequence.
  initial begin
    checkCount        = 0;
    errorCount        = 0;
    rst_in            = 1'b1;
    dmem_req_ready_in = 1'b0;
    dmem_rsp_valid_in = 1'b0;
    dmem_rdata_in     = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_busy", {31'b0, busy_out}, 32'd0);
    checkOutput("rst_req_valid", {31'b0, dmem_req_valid_out}, 32'd0);
    checkOutput("rst_fault", {31'b0, fault_out}, 32'd0);
    checkOutput("rst_load_valid", {31'b0, load_valid_out}, 32'd0);
    checkOutput("rst_be", {28'b0, dmem_be_out}, 32'd0);
    rst_in = 1'b0;
    tick();

    $display("[TB] SW with ready in the first REQ cycle");
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
    checkOutput("sw_busy_accept", {31'b0, busy_out}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_req_ready_in = 1'b1;
    checkOutput("sw_req_valid", {31'b0, dmem_req_valid_out}, 32'd1);
    checkOutput("sw_addr", dmem_addr_out, 32'h100);
    checkOutput("sw_be", {28'b0, dmem_be_out}, 32'hF);
    checkOutput("sw_we", {31'b0, dmem_we_out}, 32'd1);
    checkOutput("sw_wdata", dmem_wdata_out, 32'hDEADBEEF);
    checkOutput("sw_busy_req", {31'b0, busy_out}, 32'd1);
    tick();
    dmem_req_ready_in = 1'b0;
    #1;
    checkOutput("sw_busy_done", {31'b0, busy_out}, 32'd0);
    checkOutput("sw_req_valid_done", {31'b0, dmem_req_valid_out}, 32'd0);
    checkOutput("sw_no_load_valid", {31'b0, load_valid_out}, 32'd0);
    tick();
    checkOutput("sw_no_load_valid2", {31'b0, load_valid_out}, 32'd0);

    $display("[TB] byte and halfword loads");
    runLoad("lb", 3'b000, 32'h203, 5'd5, 32'h80FF_0000, 32'hFFFF_FF80);
    runLoad("lbu", 3'b100, 32'h203, 5'd6, 32'h80FF_0000, 32'h0000_0080);
    runLoad("lh", 3'b001, 32'h102, 5'd7, 32'h8001_1234, 32'hFFFF_8001);
    runLoad("lhu", 3'b101, 32'h102, 5'd8, 32'h8001_1234, 32'h0000_8001);

    $display("[TB] illegal requests");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd1);
    checkOutput("lw102_busy", {31'b0, busy_out}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    checkOutput("lw102_fault", {31'b0, fault_out}, 32'd1);
    checkOutput("lw102_no_req", {31'b0, dmem_req_valid_out}, 32'd0);
    tick();
    checkOutput("lw102_fault_pulse", {31'b0, fault_out}, 32'd0);
    checkOutput("lw102_no_req2", {31'b0, dmem_req_valid_out}, 32'd0);

    applyStimulus(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd1);
    checkOutput("lh101_busy", {31'b0, busy_out}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    checkOutput("lh101_fault", {31'b0, fault_out}, 32'd1);
    checkOutput("lh101_no_req", {31'b0, dmem_req_valid_out}, 32'd0);
    tick();
    checkOutput("lh101_fault_pulse", {31'b0, fault_out}, 32'd0);

    applyStimulus(1'b1, 1'b1, 3'b100, 32'h40, 32'h55, 5'd0);
    checkOutput("sbu_busy", {31'b0, busy_out}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    checkOutput("sbu_fault", {31'b0, fault_out}, 32'd1);
    tick();

    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 5'd0);
    checkOutput("f3_011_busy", {31'b0, busy_out}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    checkOutput("f3_011_fault", {31'b0, fault_out}, 32'd1);
    tick();

    $display("[TB] SH with ready withheld");
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h002, 32'h1234ABCD, 5'd0);
    checkOutput("sh_busy_accept", {31'b0, busy_out}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("sh_wait_req_valid", {31'b0, dmem_req_valid_out}, 32'd1);
      checkOutput("sh_wait_be", {28'b0, dmem_be_out}, 32'hC);
      checkOutput("sh_wait_wdata", dmem_wdata_out, 32'hABCDABCD);
      checkOutput("sh_wait_addr", dmem_addr_out, 32'h0);
      checkOutput("sh_wait_busy", {31'b0, busy_out}, 32'd1);
      tick();
    end
    dmem_req_ready_in = 1'b1;
    #1;
    checkOutput("sh_req_valid_final", {31'b0, dmem_req_valid_out}, 32'd1);
    tick();
    dmem_req_ready_in = 1'b0;
    #1;
    checkOutput("sh_busy_done", {31'b0, busy_out}, 32'd0);
    checkOutput("sh_req_valid_done", {31'b0, dmem_req_valid_out}, 32'd0);

    $display("[TB] reset while a load waits for its response");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd7);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_req_ready_in = 1'b1;
    tick();
    dmem_req_ready_in = 1'b0;
    #1;
    checkOutput("rstrsp_in_rsp_busy", {31'b0, busy_out}, 32'd1);
    checkOutput("rstrsp_in_rsp_req_valid", {31'b0, dmem_req_valid_out}, 32'd0);
    rst_in = 1'b1;
    #1;
    checkOutput("rstrsp_busy", {31'b0, busy_out}, 32'd0);
    checkOutput("rstrsp_addr", dmem_addr_out, 32'h0);
    checkOutput("rstrsp_be", {28'b0, dmem_be_out}, 32'h0);
    checkOutput("rstrsp_wdata", dmem_wdata_out, 32'h0);
    checkOutput("rstrsp_load_data", load_data_out, 32'h0);
    checkOutput("rstrsp_load_rd", {27'b0, load_rd_out}, 32'h0);
    tick();
    rst_in            = 1'b0;
    dmem_rsp_valid_in = 1'b1;
    dmem_rdata_in     = 32'hCAFEF00D;
    tick();
    dmem_rsp_valid_in = 1'b0;
    dmem_rdata_in     = 32'h0;
    #1;
    checkOutput("rstrsp_no_load_valid", {31'b0, load_valid_out}, 32'd0);
    checkOutput("rstrsp_data_zero", load_data_out, 32'h0);
    checkOutput("rstrsp_idle_busy", {31'b0, busy_out}, 32'd0);
    checkOutput("rstrsp_idle_req", {31'b0, dmem_req_valid_out}, 32'd0);
    tick();

    $display("[TB] LW followed immediately by SB");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd9);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_req_ready_in = 1'b1;
    tick();
    dmem_req_ready_in = 1'b0;
    dmem_rsp_valid_in = 1'b1;
    dmem_rdata_in     = 32'h11223344;
    tick();
    dmem_rsp_valid_in = 1'b0;
    dmem_rdata_in     = 32'h0;
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h5, 32'h000000A5, 5'd0);
    checkOutput("b2b_load_valid", {31'b0, load_valid_out}, 32'd1);
    checkOutput("b2b_load_data", load_data_out, 32'h11223344);
    checkOutput("b2b_load_rd", {27'b0, load_rd_out}, 32'd9);
    checkOutput("b2b_sb_busy", {31'b0, busy_out}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    checkOutput("b2b_load_valid_drop", {31'b0, load_valid_out}, 32'd0);
    checkOutput("b2b_sb_req_valid", {31'b0, dmem_req_valid_out}, 32'd1);
    checkOutput("b2b_sb_be", {28'b0, dmem_be_out}, 32'h2);
    checkOutput("b2b_sb_addr", dmem_addr_out, 32'h4);
    checkOutput("b2b_sb_wdata", dmem_wdata_out, 32'hA5A5A5A5);
    checkOutput("b2b_sb_we", {31'b0, dmem_we_out}, 32'd1);
    dmem_req_ready_in = 1'b1;
    tick();
    dmem_req_ready_in = 1'b0;
    #1;
    checkOutput("b2b_busy_done", {31'b0, busy_out}, 32'd0);
    checkOutput("b2b_data_hold", load_data_out, 32'h11223344);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
